// File: rtl/sdram_clk_reset_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock,
// holds the SDRAM power-up delay, then releases the system reset.
module sdram_clk_reset_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SDRAM_INIT_CYCLES   = 10000,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 17
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_lost,
  output logic       lock_timeout,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_PLL_RST    = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_STABLE     = 3'd2,
    S_SDRAM_WAIT = 3'd3,
    S_RUN        = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LD_PLL = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STB = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_SDR = CNT_W'(SDRAM_INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TO  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             locked_s, cnt_zero;
  logic             pll_rst_q, sys_rst_n_q, lost_q, lost_d, to_q, to_d;
  logic [7:0]       relock_q, relock_d;

  // pll_locked is asynchronous to clk; two-flop synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], pll_locked};
  end

  assign locked_s = sync_q[1];
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    lost_d   = 1'b0;
    to_d     = 1'b0;
    relock_d = relock_q;
    // lock-drop checks are tested before counter expiry in every state
    case (state_q)
      S_PLL_RST: begin
        if (cnt_zero) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = LD_TO;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = LD_STB;
        end else if (cnt_zero) begin
          state_d = S_PLL_RST;
          cnt_d   = LD_PLL;
          to_d    = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = LD_TO;
        end else if (cnt_zero) begin
          state_d = S_SDRAM_WAIT;
          cnt_d   = LD_SDR;
        end
      end
      S_SDRAM_WAIT: begin
        if (!locked_s) begin
          state_d = S_PLL_RST;
          cnt_d   = LD_PLL;
        end else if (cnt_zero) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_PLL_RST;
          cnt_d   = LD_PLL;
          lost_d  = 1'b1;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = LD_PLL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= LD_PLL;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lost_q      <= 1'b0;
      to_q        <= 1'b0;
      relock_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= (state_d == S_PLL_RST);
      sys_rst_n_q <= (state_d == S_RUN);
      lost_q      <= lost_d;
      to_q        <= to_d;
      relock_q    <= relock_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_reset_n  = sys_rst_n_q;
  assign lock_lost    = lost_q;
  assign lock_timeout = to_q;
  assign relock_count = relock_q;
  assign state        = state_q;

endmodule

// File: tb/tb_sdram_clk_reset_seq.sv
// Bench for sdram_clk_reset_seq: directed timing points plus random lock
// patterns compared each edge against a phase/elapsed-time reference model.
module tb_sdram_clk_reset_seq;

  localparam int PLL = 4, STB = 8, SDR = 16, TO = 32;

  logic       clk = 1'b0, reset_n = 1'b0, pll_locked = 1'b1;
  logic       pll_rst, sys_reset_n, lock_lost, lock_timeout;
  logic [7:0] relock_count;
  logic [2:0] state;

  int errors = 0, checks = 0, ec = 0;

  // reference model: phase index, cycles spent in phase, pin samples in flight
  int m_phase, m_elapsed, m_rc;
  bit m_ll, m_to;
  bit lq[$];

  sdram_clk_reset_seq #(
    .PLL_RST_CYCLES(PLL), .LOCK_STABLE_CYCLES(STB),
    .SDRAM_INIT_CYCLES(SDR), .LOCK_TIMEOUT_CYCLES(TO), .CNT_W(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .lock_lost(lock_lost),
    .lock_timeout(lock_timeout), .relock_count(relock_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, ec);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_rc = 0; m_ll = 0; m_to = 0;
    lq = '{1'b0, 1'b0};
  endtask

  task automatic go(input int p);
    m_phase = p; m_elapsed = 0;
  endtask

  task automatic model_edge(input bit pin);
    bit ls;
    ls = lq.pop_front();
    lq.push_back(pin);
    m_ll = 0; m_to = 0;
    m_elapsed++;
    case (m_phase)
      0: if (m_elapsed == PLL) go(1);
      1: if (ls) go(2); else if (m_elapsed == TO) begin go(0); m_to = 1; end
      2: if (!ls) go(1); else if (m_elapsed == STB) go(3);
      3: if (!ls) go(0); else if (m_elapsed == SDR) go(4);
      default: if (!ls) begin
        go(0); m_ll = 1;
        if (m_rc < 255) m_rc++;
      end
    endcase
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_phase));
    chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(m_phase == 0));
    chk({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(m_phase == 4));
    chk({tag, ".lock_lost"}, 32'(lock_lost), 32'(m_ll));
    chk({tag, ".lock_timeout"}, 32'(lock_timeout), 32'(m_to));
    chk({tag, ".relock_count"}, 32'(relock_count), 32'(m_rc));
  endtask

  // called at a negedge; drives the pin, takes one rising edge, checks after it
  task automatic step(input bit pin, input string tag);
    pll_locked = pin;
    @(posedge clk);
    ec++;
    model_edge(pin);
    #1 cmp_all(tag);
    @(negedge clk);
  endtask

  // asynchronous assertion mid-cycle, released on a negedge
  task automatic apply_reset(input bit pin);
    pll_locked = pin;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst.state", 32'(state), 0);
    chk("rst.pll_rst", 32'(pll_rst), 1);
    chk("rst.sys_reset_n", 32'(sys_reset_n), 0);
    chk("rst.lock_lost", 32'(lock_lost), 0);
    chk("rst.lock_timeout", 32'(lock_timeout), 0);
    chk("rst.relock_count", 32'(relock_count), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ec = 0;
  endtask

  initial begin
    int lose_edge, run_len;
    bit pin;

    // 1: lock held high, nominal bring-up
    @(negedge clk);
    apply_reset(1'b1);
    for (int i = 0; i < 35; i++) begin
      step(1'b1, "boot");
      if (ec == 1)  chk("boot.state_E1", 32'(state), 0);
      if (ec == 3)  chk("boot.pll_rst_E3", 32'(pll_rst), 1);
      if (ec == 4)  begin chk("boot.pll_fall_E4", 32'(pll_rst), 0); chk("boot.state_E4", 32'(state), 1); end
      if (ec == 5)  chk("boot.state_E5", 32'(state), 2);
      if (ec == 13) chk("boot.state_E13", 32'(state), 3);
      if (ec == 28) chk("boot.sys_E28", 32'(sys_reset_n), 0);
      if (ec == 29) begin chk("boot.sys_E29", 32'(sys_reset_n), 1); chk("boot.state_E29", 32'(state), 4); end
    end

    // 2: lock drop in RUN, reacts on the 3rd edge, relock 29 edges later
    lose_edge = ec + 3;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, "drop");
      if (ec < lose_edge) chk("drop.sys_before", 32'(sys_reset_n), 1);
    end
    chk("drop.sys", 32'(sys_reset_n), 0);
    chk("drop.pll_rst", 32'(pll_rst), 1);
    chk("drop.lock_lost", 32'(lock_lost), 1);
    chk("drop.relock_count", 32'(relock_count), 1);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, "relock");
      if (ec == lose_edge + 1)  chk("relock.lost_clear", 32'(lock_lost), 0);
      if (ec == lose_edge + 28) chk("relock.sys_L28", 32'(sys_reset_n), 0);
      if (ec == lose_edge + 29) chk("relock.sys_L29", 32'(sys_reset_n), 1);
    end

    // 3: 2-cycle glitch during STABLE restarts stability and SDRAM wait
    apply_reset(1'b1);
    for (int i = 0; i < 36; i++) begin
      step((ec >= 6 && ec < 8) ? 1'b0 : 1'b1, "glitch");
      if (ec == 9)  chk("glitch.state_E9", 32'(state), 1);
      if (ec == 29) chk("glitch.sys_E29", 32'(sys_reset_n), 0);
      if (ec == 34) chk("glitch.sys_E34", 32'(sys_reset_n), 0);
      if (ec == 35) chk("glitch.sys_E35", 32'(sys_reset_n), 1);
    end

    // 4: lock never arrives, periodic timeout every 36 edges
    apply_reset(1'b0);
    for (int i = 0; i < 80; i++) begin
      step(1'b0, "tmo");
      if (ec == 35) chk("tmo.to_E35", 32'(lock_timeout), 0);
      if (ec == 36 || ec == 72) chk("tmo.to_pulse", 32'(lock_timeout), 1);
      if (ec == 37) chk("tmo.to_clear", 32'(lock_timeout), 0);
      if (ec >= 36 && ec <= 39) chk("tmo.pll_rst_hi", 32'(pll_rst), 1);
      if (ec == 40) chk("tmo.pll_rst_lo", 32'(pll_rst), 0);
      if (ec == 41) chk("tmo.sys", 32'(sys_reset_n), 0);
    end

    // 5: reset pulsed during SDRAM_WAIT, full sequence again
    apply_reset(1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, "pre_mid");
    chk("mid.state_sdram", 32'(state), 3);
    apply_reset(1'b1);
    for (int i = 0; i < 29; i++) begin
      step(1'b1, "mid");
      if (ec == 28) chk("mid.sys_E28", 32'(sys_reset_n), 0);
      if (ec == 29) chk("mid.sys_E29", 32'(sys_reset_n), 1);
    end

    // 6: 257 losses, counter saturates while lock_lost keeps pulsing
    for (int k = 0; k < 257; k++) begin
      for (int w = 0; w < 40 && m_phase != 4; w++) step(1'b1, "sat_up");
      for (int d = 0; d < 3; d++) step(1'b0, "sat_drop");
      chk("sat.lost_pulse", 32'(lock_lost), 1);
      if (k == 254) chk("sat.rc_255", 32'(relock_count), 255);
    end
    chk("sat.rc_hold", 32'(relock_count), 255);

    // 7: random lock patterns against the model
    apply_reset(1'b1);
    for (int n = 0; n < 2500; ) begin
      pin = ($urandom_range(0, 9) < 7);
      run_len = pin ? $urandom_range(1, 60) : $urandom_range(1, 6);
      for (int j = 0; j < run_len; j++) begin
        step(pin, "rand");
        n++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
